// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if
//   Bundles the CPU note-event stream and the synth-side handshake of the
//   voice scheduler.
//   master : event source / cdc side (drives ev_valid, ev_cmd, ev_fcw, tx_ack)
//   slave  : the scheduler itself (drives ev_ready, carrier_fcws, note_en,
//            tx_req, last_voice, steal_cnt)
interface voice_scheduler_if #(
    parameter int N_VOICES = 4,
    parameter int FCW_W    = 24
);
    localparam int VW = $clog2(N_VOICES);

    logic                               ev_valid;
    logic                               ev_ready;
    logic [1:0]                         ev_cmd;
    logic [FCW_W-1:0]                   ev_fcw;
    logic [N_VOICES-1:0][FCW_W-1:0]     carrier_fcws;
    logic [N_VOICES-1:0]                note_en;
    logic                               tx_req;
    logic                               tx_ack;
    logic [VW-1:0]                      last_voice;
    logic [7:0]                         steal_cnt;

    modport master (
        output ev_valid, ev_cmd, ev_fcw, tx_ack,
        input  ev_ready, carrier_fcws, note_en, tx_req, last_voice, steal_cnt
    );

    modport slave (
        input  ev_valid, ev_cmd, ev_fcw, tx_ack,
        output ev_ready, carrier_fcws, note_en, tx_req, last_voice, steal_cnt
    );
endinterface

// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Polyphonic voice allocator in the cpu_clk domain. Maps note-on/off and
//   all-off events onto N_VOICES carrier NCOs using lowest-free allocation
//   and least-recently-triggered stealing, then publishes every change of
//   voice state to the synth domain through a 4-phase req/ack handshake.
// Ports
//   clk  : cpu_clk, rising edge
//   rst  : synchronous, active-high reset
//   bus  : voice_scheduler_if.slave
//          ev_valid/ev_ready/ev_cmd/ev_fcw  event stream (00 off, 01 on,
//                                           10 all-off, 11 no-op)
//          carrier_fcws/note_en            voice state towards the cdc
//          tx_req/tx_ack                   4-phase handshake
//          last_voice                      voice touched by last note-on/off
//          steal_cnt                       saturating steal counter
module voice_scheduler #(
    parameter int N_VOICES = 4,
    parameter int FCW_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    voice_scheduler_if.slave    bus
);
    localparam int VW = $clog2(N_VOICES);

    typedef logic [VW-1:0] vidx_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, REQ, WAIT_LO} state_t;

    localparam logic [1:0] CMD_OFF = 2'b00;
    localparam logic [1:0] CMD_ON  = 2'b01;
    localparam logic [1:0] CMD_ALL = 2'b10;

    state_t                         state_q, state_d;
    logic [1:0]                     cmd_q;
    logic [FCW_W-1:0]               fcw_q;
    logic [N_VOICES-1:0][FCW_W-1:0] fcws_q, fcws_d;
    logic [N_VOICES-1:0]            en_q, en_d;
    vidx_t                          rank_q [N_VOICES];
    vidx_t                          rank_d [N_VOICES];
    vidx_t                          last_q, last_d;
    logic [7:0]                     steal_q, steal_d;
    logic                           tx_req_q, tx_req_d;
    logic                           chg;

    logic                           match_hit, free_hit, on_hit;
    vidx_t                          match_idx, free_idx, old_idx, on_idx;

    // Priority searches; iterating downwards lets the lowest index win.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        old_idx   = '0;
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (en_q[i] && (fcws_q[i] == fcw_q)) begin
                match_hit = 1'b1;
                match_idx = vidx_t'(i);
            end
            if (!en_q[i]) begin
                free_hit = 1'b1;
                free_idx = vidx_t'(i);
            end
            if (rank_q[i] == vidx_t'(N_VOICES - 1)) begin
                old_idx = vidx_t'(i);
            end
        end
    end

    // Voice-state update, only evaluated in LOOKUP; elsewhere everything holds.
    always_comb begin
        fcws_d  = fcws_q;
        en_d    = en_q;
        rank_d  = rank_q;
        last_d  = last_q;
        steal_d = steal_q;
        chg     = 1'b0;
        on_hit  = 1'b0;
        on_idx  = '0;
        if (state_q == LOOKUP) begin
            case (cmd_q)
                CMD_ON: begin
                    if (fcw_q != '0) begin
                        on_hit = 1'b1;
                        if (match_hit) begin
                            // Retrigger: only the LRU order moves.
                            on_idx = match_idx;
                        end else if (free_hit) begin
                            on_idx           = free_idx;
                            en_d[free_idx]   = 1'b1;
                            fcws_d[free_idx] = fcw_q;
                            chg              = 1'b1;
                        end else begin
                            on_idx          = old_idx;
                            fcws_d[old_idx] = fcw_q;
                            chg             = 1'b1;
                            if (steal_q != 8'hFF) begin
                                steal_d = steal_q + 8'd1;
                            end
                        end
                        last_d = on_idx;
                    end
                end
                CMD_OFF: begin
                    if (match_hit) begin
                        en_d[match_idx] = 1'b0;
                        last_d          = match_idx;
                        chg             = 1'b1;
                    end
                end
                CMD_ALL: begin
                    en_d = '0;
                    chg  = |en_q;
                end
                default: ;
            endcase
        end
        // Touched voice becomes most recent; younger voices age by one,
        // which keeps the ranks a permutation.
        if (on_hit) begin
            for (int j = 0; j < N_VOICES; j++) begin
                if (vidx_t'(j) == on_idx) begin
                    rank_d[j] = '0;
                end else if (rank_q[j] < rank_q[on_idx]) begin
                    rank_d[j] = rank_q[j] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_req_d = tx_req_q;
        case (state_q)
            IDLE: begin
                if (bus.ev_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (chg) begin
                    state_d  = REQ;
                    tx_req_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.tx_ack) begin
                    tx_req_d = 1'b0;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_req_q <= 1'b0;
            fcws_q   <= '0;
            en_q     <= '0;
            last_q   <= '0;
            steal_q  <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                rank_q[i] <= vidx_t'(i);
            end
        end else begin
            state_q  <= state_d;
            tx_req_q <= tx_req_d;
            fcws_q   <= fcws_d;
            en_q     <= en_d;
            last_q   <= last_d;
            steal_q  <= steal_d;
            rank_q   <= rank_d;
        end
    end

    // Event capture is pure data; it is only consumed in LOOKUP.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.ev_valid) begin
            cmd_q <= bus.ev_cmd;
            fcw_q <= bus.ev_fcw;
        end
    end

    assign bus.ev_ready     = (state_q == IDLE);
    assign bus.carrier_fcws = fcws_q;
    assign bus.note_en      = en_q;
    assign bus.tx_req       = tx_req_q;
    assign bus.last_voice   = last_q;
    assign bus.steal_cnt    = steal_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler
//   Randomized and directed stimulus for voice_scheduler, compared against a
//   behavioural model that keeps voices in plain arrays and the trigger
//   history as a most-recent-first queue.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int FW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    voice_scheduler_if #(.N_VOICES(NV), .FCW_W(FW)) vif ();

    voice_scheduler #(.N_VOICES(NV), .FCW_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [FW-1:0] m_fcw [NV];
    logic [NV-1:0] m_en;
    int            order[$];
    int            m_last;
    int            m_steal;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = '0;
        order.delete();
        for (int i = 0; i < NV; i++) begin
            m_fcw[i] = '0;
            order.push_back(i);
        end
        m_last  = 0;
        m_steal = 0;
    endfunction

    function automatic void touch(input int v);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == v) begin
                order.delete(k);
                break;
            end
        end
        order.push_front(v);
    endfunction

    function automatic bit model_apply(input logic [1:0] cmd, input logic [FW-1:0] f);
        bit chg;
        int v;
        chg = 1'b0;
        v   = -1;
        case (cmd)
            2'b01: begin
                if (f != '0) begin
                    for (int i = 0; i < NV; i++)
                        if (v < 0 && m_en[i] && m_fcw[i] == f) v = i;
                    if (v < 0) begin
                        for (int i = 0; i < NV; i++)
                            if (v < 0 && !m_en[i]) v = i;
                        if (v >= 0) begin
                            m_en[v]  = 1'b1;
                            m_fcw[v] = f;
                        end else begin
                            v        = order[NV-1];
                            m_fcw[v] = f;
                            if (m_steal < 255) m_steal++;
                        end
                        chg = 1'b1;
                    end
                    touch(v);
                    m_last = v;
                end
            end
            2'b00: begin
                for (int i = 0; i < NV; i++)
                    if (v < 0 && m_en[i] && m_fcw[i] == f) v = i;
                if (v >= 0) begin
                    m_en[v] = 1'b0;
                    m_last  = v;
                    chg     = 1'b1;
                end
            end
            2'b10: begin
                chg  = |m_en;
                m_en = '0;
            end
            default: chg = 1'b0;
        endcase
        return chg;
    endfunction

    function automatic logic [NV*FW-1:0] model_fcws();
        logic [NV*FW-1:0] vec;
        for (int i = 0; i < NV; i++) vec[i*FW +: FW] = m_fcw[i];
        return vec;
    endfunction

    task automatic check_outputs(input string pfx);
        logic [31:0] lv;
        lv = m_last;
        check({pfx, "_note_en"}, vif.note_en, m_en);
        check({pfx, "_fcws"}, vif.carrier_fcws, model_fcws());
        check({pfx, "_last_voice"}, vif.last_voice, lv[1:0]);
        check({pfx, "_steal_cnt"}, vif.steal_cnt, m_steal);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        vif.ev_valid = 1'b0;
        vif.ev_cmd   = 2'b11;
        vif.ev_fcw   = '0;
        vif.tx_ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called and returns at a falling edge. ack_delay = cycles the cdc keeps
    // tx_ack low in REQ; early raises tx_ack before REQ is even entered;
    // queue_all keeps an all-off pending on ev_valid during the handshake.
    task automatic run_event(input logic [1:0] cmd, input logic [FW-1:0] f,
                             input int ack_delay, input bit early, input bit queue_all);
        bit exp_chg;
        int n;
        vif.ev_cmd   = cmd;
        vif.ev_fcw   = f;
        vif.ev_valid = 1'b1;
        n = 0;
        while (!vif.ev_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 0, 1);
            vif.ev_valid = 1'b0;
            return;
        end
        @(negedge clk);
        vif.ev_valid = 1'b0;
        check("lookup_ready", vif.ev_ready, 0);
        exp_chg = model_apply(cmd, f);
        if (early && exp_chg) vif.tx_ack = 1'b1;
        @(negedge clk);
        check("tx_req", vif.tx_req, exp_chg);
        check_outputs("ev");
        if (exp_chg) begin
            if (queue_all) begin
                vif.ev_cmd   = 2'b10;
                vif.ev_fcw   = '0;
                vif.ev_valid = 1'b1;
            end
            for (int k = 0; k < ack_delay && !early; k++) begin
                @(negedge clk);
                check("req_hold", vif.tx_req, 1);
                check("req_busy", vif.ev_ready, 0);
                check("req_en_frozen", vif.note_en, m_en);
                check("req_fcw_frozen", vif.carrier_fcws, model_fcws());
            end
            vif.tx_ack = 1'b1;
            @(negedge clk);
            check("req_drop", vif.tx_req, 0);
            check("wait_busy", vif.ev_ready, 0);
            vif.tx_ack = 1'b0;
            @(negedge clk);
        end
        check("ev_ready", vif.ev_ready, 1);
    endtask

    initial begin
        logic [FW-1:0] pool [7];
        pool[0] = 24'h000000; pool[1] = 24'h000101; pool[2] = 24'h000102;
        pool[3] = 24'h000103; pool[4] = 24'h000104; pool[5] = 24'h000105;
        pool[6] = 24'h000106;

        // Reset state and first note-on
        do_reset();
        check("rst_ready", vif.ev_ready, 1);
        check("rst_tx_req", vif.tx_req, 0);
        check("rst_note_en", vif.note_en, 0);
        check("rst_fcws", vif.carrier_fcws, 0);
        check("rst_last", vif.last_voice, 0);
        check("rst_steal", vif.steal_cnt, 0);
        run_event(2'b01, 24'h00A000, 2, 1'b0, 1'b0);
        check("t1_en", vif.note_en, 4'b0001);
        check("t1_fcw0", vif.carrier_fcws[0], 24'h00A000);

        // Fill all voices then steal the oldest
        do_reset();
        for (int i = 0; i < 5; i++) run_event(2'b01, 24'h00A000 + 24'(i * 16), 0, 1'b0, 1'b0);
        check("t2_en", vif.note_en, 4'b1111);
        check("t2_fcw0", vif.carrier_fcws[0], 24'h00A040);
        check("t2_steal", vif.steal_cnt, 1);
        check("t2_last", vif.last_voice, 0);

        // Retrigger refreshes A, so B in voice 1 is stolen
        do_reset();
        run_event(2'b01, 24'h0000A0, 1, 1'b0, 1'b0);
        run_event(2'b01, 24'h0000B0, 0, 1'b1, 1'b0);
        run_event(2'b01, 24'h0000A0, 0, 1'b0, 1'b0);
        run_event(2'b01, 24'h0000C0, 0, 1'b0, 1'b0);
        run_event(2'b01, 24'h0000D0, 0, 1'b0, 1'b0);
        run_event(2'b01, 24'h0000E0, 0, 1'b0, 1'b0);
        check("t3_last", vif.last_voice, 1);
        check("t3_fcw1", vif.carrier_fcws[1], 24'h0000E0);

        // Events without a state change
        do_reset();
        run_event(2'b00, 24'h000777, 0, 1'b0, 1'b0);
        run_event(2'b01, 24'h000000, 0, 1'b0, 1'b0);
        run_event(2'b11, 24'h000123, 0, 1'b0, 1'b0);
        run_event(2'b10, 24'h000000, 0, 1'b0, 1'b0);

        // Long ack stall with an all-off queued behind it
        do_reset();
        run_event(2'b01, 24'h000200, 0, 1'b0, 1'b0);
        run_event(2'b01, 24'h000300, 50, 1'b0, 1'b1);
        run_event(2'b10, 24'h000000, 0, 1'b0, 1'b0);
        check("t5_alloff", vif.note_en, 4'b0000);

        // Reset in the middle of a handshake
        do_reset();
        run_event(2'b01, 24'h000400, 0, 1'b0, 1'b0);
        vif.ev_cmd   = 2'b01;
        vif.ev_fcw   = 24'h000500;
        vif.ev_valid = 1'b1;
        @(negedge clk);
        vif.ev_valid = 1'b0;
        @(negedge clk);
        check("t6_req_before", vif.tx_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_req_abort", vif.tx_req, 0);
        check("t6_en_clear", vif.note_en, 0);
        check("t6_ready", vif.ev_ready, 1);
        rst = 1'b0;
        model_reset();
        // Identity ranks after reset decide which voice is stolen here
        for (int i = 0; i < 5; i++) run_event(2'b01, 24'h000600 + 24'(i), 0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) run_event(2'b01, 24'h001000 + 24'(i), 0, (i % 3) == 0, 1'b0);
        check("t6_steal_sat", vif.steal_cnt, 8'd255);

        // Random traffic over a small key pool so matches and steals occur
        do_reset();
        for (int i = 0; i < 300; i++) begin
            run_event(2'($urandom_range(0, 3)), pool[$urandom_range(0, 6)],
                      int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
